// File: rtl/fifo_rd_fwft_pkg.sv
// Shared constants and helpers for the FIFO read side: pointer width,
// output-buffer depth and level width.
package fifo_rd_fwft_pkg;

    localparam int PTR_W     = 2;
    localparam int BUF_DEPTH = 3;
    localparam int LEVEL_W   = 2;

    typedef logic [PTR_W-1:0]   ptr_t;
    typedef logic [LEVEL_W-1:0] level_t;

    // Circular index over a buffer that is not a power of two deep.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(BUF_DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

endpackage

// File: rtl/fifo_rd_fwft.sv
// First-word-fall-through adapter on the FIFO read side: prefetches into a
// 3-entry buffer so dout is presented without waiting on the one-cycle read.
module fifo_rd_fwft
    import fifo_rd_fwft_pkg::*;
#(
    parameter int DW  = 8,
    parameter int BUF = BUF_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rempty,
    input  logic [DW-1:0] rdata,
    output logic          rinc,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic [1:0]    level
);

    logic [DW-1:0] mem [BUF_DEPTH];
    ptr_t          wr_idx;
    ptr_t          rd_idx;
    level_t        occ;
    logic          inflight;
    logic          pop;
    logic [LEVEL_W:0] committed;

    // Words already buffered plus the one still coming back from memory; a
    // new read is only issued when a slot is guaranteed for it, so the
    // consumer's ready never reaches rinc combinationally.
    assign committed  = {1'b0, occ} + {{LEVEL_W{1'b0}}, inflight};
    assign rinc       = ~rst & ~rempty & (committed < (LEVEL_W + 1)'(BUF));

    assign dout_valid = (occ != '0);
    assign pop        = dout_valid & dout_ready;
    assign dout       = mem[rd_idx];
    assign level      = occ;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ      <= '0;
            inflight <= 1'b0;
            wr_idx   <= '0;
            rd_idx   <= '0;
        end else begin
            inflight <= rinc;
            if (inflight) begin
                wr_idx <= ptr_inc(wr_idx);
            end
            if (pop) begin
                rd_idx <= ptr_inc(rd_idx);
            end
            occ <= occ + level_t'(inflight) - level_t'(pop);
        end
    end

    // Storage carries no reset; occ alone decides what is valid.
    always_ff @(posedge clk) begin
        if (inflight) begin
            mem[wr_idx] <= rdata;
        end
    end

endmodule

// File: tb/tb_fifo_rd_fwft.sv
// Bench for fifo_rd_fwft: directed scenarios plus a randomized stream, all
// checked against a word-queue reference of the upstream FIFO and consumer.
module tb_fifo_rd_fwft;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          rempty;
    logic [DW-1:0] rdata;
    logic          rinc;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;
    logic [1:0]    level;

    always #5 clk = ~clk;

    fifo_rd_fwft #(.DW(DW), .BUF(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .rempty     (rempty),
        .rdata      (rdata),
        .rinc       (rinc),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .level      (level)
    );

    int            vectors = 0;
    int            miscompares = 0;

    // Reference: every requested word in request order; model_level counts
    // words that have arrived but not been consumed.
    logic [DW-1:0] exp_q[$];
    int            model_level;
    logic          model_infl;
    int            cyc;
    int            pops;
    int            pop_cycles[$];
    logic          seq_mode;
    logic [DW-1:0] seq_cnt;

    logic          last_rinc;
    logic          last_dv;
    logic [1:0]    last_level;
    logic [DW-1:0] last_dout;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        pop_cycles.delete();
        model_level = 0;
        model_infl  = 1'b0;
        cyc         = 0;
        pops        = 0;
    endtask

    // One clock cycle: drive, sample at the falling edge, check, advance model.
    task automatic cycle(input logic re, input logic rdy);
        logic          exp_rinc;
        logic          m_pop;
        logic [DW-1:0] w;
        w          = '0;
        rempty     = re;
        dout_ready = rdy;
        @(negedge clk);
        exp_rinc = !re && (model_level + int'(model_infl) < 3);
        check("rinc", rinc, exp_rinc);
        check("level", level, model_level);
        check("dout_valid", dout_valid, model_level != 0);
        if (model_level != 0) begin
            check("dout", dout, exp_q[0]);
        end
        last_rinc  = rinc;
        last_dv    = dout_valid;
        last_level = level;
        last_dout  = dout;
        m_pop = (model_level != 0) && rdy;
        if (m_pop) begin
            void'(exp_q.pop_front());
            pops++;
            pop_cycles.push_back(cyc);
        end
        model_level = model_level + int'(model_infl) - int'(m_pop);
        model_infl  = exp_rinc;
        if (exp_rinc) begin
            w = seq_mode ? seq_cnt : DW'($urandom);
            seq_cnt++;
            exp_q.push_back(w);
        end
        @(posedge clk);
        #1;
        rdata = exp_rinc ? w : DW'($urandom);
        cyc++;
    endtask

    task automatic apply_reset();
        rst        = 1'b1;
        rempty     = 1'b0;
        dout_ready = 1'b0;
        rdata      = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rinc", rinc, 1'b0);
        check("rst_dout_valid", dout_valid, 1'b0);
        check("rst_level", level, 2'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int exp_rinc_1w[5];
        int exp_dv_1w[5];
        int exp_lvl_1w[5];
        int n;

        rst        = 1'b1;
        rempty     = 1'b1;
        dout_ready = 1'b0;
        rdata      = '0;
        seq_mode   = 1'b1;
        seq_cnt    = '0;

        // Fill with consumer stalled: three reads, then throttled.
        apply_reset();
        seq_cnt = 8'hA0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b0);
            check("fill_rinc", last_rinc, (i < 3) ? 1'b1 : 1'b0);
        end
        check("fill_level", last_level, 2'd3);
        check("fill_dout", last_dout, 8'hA0);

        // Hold while full, then release the consumer.
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0);
            check("hold_dout", last_dout, 8'hA0);
            check("hold_dout_valid", last_dv, 1'b1);
            check("hold_rinc", last_rinc, 1'b0);
        end
        cycle(1'b0, 1'b1);
        check("release_rinc_same", last_rinc, 1'b0);
        cycle(1'b0, 1'b0);
        check("release_rinc_next", last_rinc, 1'b1);
        repeat (8) cycle(1'b1, 1'b1);
        check("hold_drain_level", last_level, 2'd0);

        // Sixteen-word burst with consumer always ready.
        apply_reset();
        seq_cnt = 8'h00;
        for (int i = 0; i < 24; i++) begin
            cycle((seq_cnt >= 8'd16) ? 1'b1 : 1'b0, 1'b1);
        end
        check("burst_count", pops, 16);
        for (int k = 0; k < pop_cycles.size(); k++) begin
            check("burst_cycle", pop_cycles[k], k + 2);
        end

        // Single word.
        apply_reset();
        seq_cnt = 8'h5A;
        exp_rinc_1w = '{1, 0, 0, 0, 0};
        exp_dv_1w   = '{0, 0, 1, 0, 0};
        exp_lvl_1w  = '{0, 0, 1, 0, 0};
        for (int i = 0; i < 5; i++) begin
            cycle((i != 0) ? 1'b1 : 1'b0, 1'b1);
            check("single_rinc", last_rinc, exp_rinc_1w[i]);
            check("single_dout_valid", last_dv, exp_dv_1w[i]);
            check("single_level", last_level, exp_lvl_1w[i]);
        end

        // Reset with two words buffered and one in flight.
        apply_reset();
        seq_cnt = 8'h30;
        repeat (3) cycle(1'b0, 1'b0);
        #1;
        check("pre_rst_level", level, 2'd2);
        check("pre_rst_dout_valid", dout_valid, 1'b1);
        rst = 1'b1;
        #1;
        check("async_rst_rinc", rinc, 1'b0);
        check("async_rst_dout_valid", dout_valid, 1'b0);
        check("async_rst_level", level, 2'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        seq_cnt = 8'h40;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1);
        end
        check("restart_dout_valid", last_dv, 1'b1);
        check("restart_dout", last_dout, 8'h40);
        repeat (6) cycle(1'b0, 1'b1);
        repeat (6) cycle(1'b1, 1'b1);
        check("restart_drain_level", last_level, 2'd0);

        // Randomized stream: 1000 words, random rempty and consumer stalls.
        apply_reset();
        seq_mode = 1'b0;
        n = 0;
        while (pops < 1000 && n < 20000) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            n++;
        end
        check("random_within_budget", (n < 20000) ? 1'b1 : 1'b0, 1'b1);
        repeat (8) cycle(1'b1, 1'b1);
        check("random_drain_level", last_level, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
